// File: rtl/mem_instr_data_arbiter_if.sv
// Bundle of the instruction port, the data port and the shared memory port around the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the core and the memory around it.
interface mem_instr_data_arbiter_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic                  instr_req_i;
  logic                  instr_gnt_o;
  logic                  instr_valid_o;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic [DATA_WIDTH-1:0] instr_rdata_o;
  logic                  instr_error_o;

  logic                  data_req_i;
  logic                  data_gnt_o;
  logic                  data_valid_o;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [BE_WIDTH-1:0]   data_be_i;
  logic                  data_we_i;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  data_error_o;

  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic                  mem_valid_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_error_i;

  logic [CNT_WIDTH-1:0]  outstanding_o;
  logic                  protocol_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_wdata_i, data_be_i, data_we_i,
    input  mem_gnt_i, mem_valid_i, mem_rdata_i, mem_error_i,
    output instr_gnt_o, instr_valid_o, instr_rdata_o, instr_error_o,
    output data_gnt_o, data_valid_o, data_rdata_o, data_error_o,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o,
    output outstanding_o, protocol_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_wdata_i, data_be_i, data_we_i,
    output mem_gnt_i, mem_valid_i, mem_rdata_i, mem_error_i,
    input  instr_gnt_o, instr_valid_o, instr_rdata_o, instr_error_o,
    input  data_gnt_o, data_valid_o, data_rdata_o, data_error_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o,
    input  outstanding_o, protocol_err_o
  );
endinterface

// File: rtl/mem_instr_data_arbiter.sv
// Shares one req/gnt/valid memory port between the instruction and data ports of a core.
// Responses are in order and are steered back to the issuer by an ID FIFO of granted ports.
module mem_instr_data_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIORITY   = 1'b0
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  mem_instr_data_arbiter_if.slave bus
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_e;

  logic                 lock_q;
  port_e                sel_q, last_q, arb_sel, sel;
  port_e                fifo_q [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 perr_q;
  logic                 full, empty, mem_req, push, pop;

  // Pointers wrap explicitly so depths that are not a power of two also work.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    arb_sel = PORT_INSTR;
    if (bus.instr_req_i && bus.data_req_i) begin
      if (DATA_PRIORITY || last_q == PORT_INSTR) arb_sel = PORT_DATA;
    end else if (bus.data_req_i) begin
      arb_sel = PORT_DATA;
    end
  end

  // A request that is already presented keeps its owner until the slave grants it.
  assign sel     = lock_q ? sel_q : arb_sel;
  assign full    = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
  assign empty   = (cnt_q == '0);
  assign mem_req = rst_ni && (bus.instr_req_i || bus.data_req_i) && !full;
  assign push    = mem_req && bus.mem_gnt_i;
  assign pop     = rst_ni && bus.mem_valid_i && !empty;

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = !mem_req ? '0 :
                           (sel == PORT_DATA) ? bus.data_addr_i : bus.instr_addr_i;
  assign bus.mem_wdata_o = (mem_req && sel == PORT_DATA) ? bus.data_wdata_i : '0;
  assign bus.mem_be_o    = !mem_req ? '0 :
                           (sel == PORT_DATA) ? bus.data_be_i : {BE_WIDTH{1'b1}};
  assign bus.mem_we_o    = mem_req && sel == PORT_DATA && bus.data_we_i;
  assign bus.instr_gnt_o = push && sel == PORT_INSTR;
  assign bus.data_gnt_o  = push && sel == PORT_DATA;

  assign bus.instr_valid_o  = pop && fifo_q[rd_ptr_q] == PORT_INSTR;
  assign bus.data_valid_o   = pop && fifo_q[rd_ptr_q] == PORT_DATA;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.instr_error_o  = bus.mem_error_i;
  assign bus.data_error_o   = bus.mem_error_i;
  assign bus.outstanding_o  = cnt_q;
  assign bus.protocol_err_o = perr_q;

  // NOTE: sequential state uses non-blocking assignments, so every block reads pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q   <= 1'b0;
      sel_q    <= PORT_INSTR;
      last_q   <= PORT_DATA;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      if (push) begin
        lock_q <= 1'b0;
        last_q <= sel;
      end else if (mem_req) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (bus.mem_valid_i && empty) perr_q <= 1'b1;
    end
  end

  // NOTE: the ID storage has no reset. The pointers and the count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end
endmodule
